lif_scheduler: RTL and testbench

- Time-multiplexes one shared leaky-integrate-and-fire update datapath across NUM_NEURONS neurons.
- Holds every neuron's membrane potential locally.
- On each time-step tick it sweeps the neuron indices in order 0..N-1. For each neuron it issues the potential to the datapath over a valid/ready handshake, accepts the updated potential and spike bit, and writes them back.
- Publishes the spike vector of the step. Sits between the TinyTapeout top wrapper (tick and input pins) and the LIF arithmetic unit.

---
 rtl/lif_pkg.sv | 22 ++
 rtl/lif_pot_regfile.sv | 44 ++++
 rtl/lif_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_lif_scheduler.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared types and constants for the LIF scheduler and the LIF datapath it feeds.
package lif_pkg;

  localparam int unsigned LifNumNeurons  = 4;
  localparam int unsigned LifVWidth      = 8;
  localparam int unsigned LifRefracTicks = 2;
  localparam int unsigned LifSpikeWidth  = 1;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StWrite,
    StDone
  } lif_state_e;

  // Index width for the neuron sweep; a single neuron still needs one bit.
  function automatic int unsigned lif_idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lif_pot_regfile.sv
// Membrane-potential storage: NUM_NEURONS x V_WIDTH, async reset, synchronous clear-all,
// one combinational read port and one write port.
module lif_pot_regfile #(
  parameter int unsigned NUM_NEURONS = 4,
  parameter int unsigned V_WIDTH     = 8,
  parameter int unsigned IDX_WIDTH   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 we_i,
  input  logic [IDX_WIDTH-1:0] wr_idx_i,
  input  logic [V_WIDTH-1:0]   wr_data_i,
  input  logic [IDX_WIDTH-1:0] rd_idx_i,
  output logic [V_WIDTH-1:0]   rd_data_o
);

  logic [V_WIDTH-1:0] mem_q [NUM_NEURONS];
  logic [V_WIDTH-1:0] mem_d [NUM_NEURONS];

  always_comb begin
    mem_d = mem_q;
    if (clr_i) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        mem_d[i] = '0;
      end
    end else if (we_i) begin
      mem_d[wr_idx_i] = wr_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/lif_scheduler.sv
// Sweeps all neurons through one shared LIF datapath per tick and publishes the spike vector.
// Optional refractory skipping is enabled with the LIF_REFRACTORY_EN macro.
module lif_scheduler import lif_pkg::*; #(
  parameter int unsigned NUM_NEURONS  = LifNumNeurons,
  parameter int unsigned V_WIDTH      = LifVWidth,
`ifdef LIF_REFRACTORY_EN
  parameter int unsigned REFRAC_TICKS = LifRefracTicks,
`endif
  localparam int unsigned IDX_WIDTH   = lif_idx_width(NUM_NEURONS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     tick_i,
  input  logic                     clr_i,
  output logic                     upd_valid_o,
  input  logic                     upd_ready_i,
  output logic [IDX_WIDTH-1:0]     upd_idx_o,
  output logic [V_WIDTH-1:0]       upd_v_o,
  input  logic                     res_valid_i,
  input  logic [V_WIDTH-1:0]       res_v_i,
  input  logic [LifSpikeWidth-1:0] res_spike_i,
  output logic [NUM_NEURONS-1:0]   spikes_o,
  output logic                     done_o,
  output logic                     busy_o,
  output logic                     overrun_o
);

  localparam logic [IDX_WIDTH-1:0] LastIdx = IDX_WIDTH'(NUM_NEURONS - 1);

  lif_state_e             state_q, state_d;
  logic [IDX_WIDTH-1:0]   idx_q, idx_d;
  logic [NUM_NEURONS-1:0] spk_q, spk_d;
  logic [NUM_NEURONS-1:0] spikes_q, spikes_d;
  logic                   overrun_q, overrun_d;
  logic                   upd_valid_q, upd_valid_d;
  logic [V_WIDTH-1:0]     upd_v_q, upd_v_d;

  logic                   pot_clr, pot_we;
  logic [V_WIDTH-1:0]     pot_wdata, pot_rdata;
  logic [IDX_WIDTH-1:0]   idx_inc, rd_idx;
  logic                   skip_cur, skip_nxt;
  logic                   advance, enter_issue;

  assign idx_inc = (idx_q == LastIdx) ? '0 : idx_q + IDX_WIDTH'(1);
  // Read port always looks at the neuron that would be issued next.
  assign rd_idx  = (state_q == StIdle) ? '0 : idx_inc;

  lif_pot_regfile #(
    .NUM_NEURONS(NUM_NEURONS),
    .V_WIDTH    (V_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_pot (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (pot_clr),
    .we_i     (pot_we),
    .wr_idx_i (idx_q),
    .wr_data_i(pot_wdata),
    .rd_idx_i (rd_idx),
    .rd_data_o(pot_rdata)
  );

`ifdef LIF_REFRACTORY_EN
  localparam int unsigned CNT_WIDTH = $clog2(REFRAC_TICKS + 1);
  logic [CNT_WIDTH-1:0] cnt_q [NUM_NEURONS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_NEURONS];

  assign skip_cur = (cnt_q[idx_q] != '0);
  assign skip_nxt = (cnt_q[rd_idx] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign skip_cur = 1'b0;
  assign skip_nxt = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    spk_d       = spk_q;
    spikes_d    = spikes_q;
    overrun_d   = overrun_q;
    upd_valid_d = upd_valid_q;
    upd_v_d     = upd_v_q;
    pot_clr     = 1'b0;
    pot_we      = 1'b0;
    pot_wdata   = res_v_i;
    advance     = 1'b0;
    enter_issue = 1'b0;
`ifdef LIF_REFRACTORY_EN
    cnt_d       = cnt_q;
`endif

    if (tick_i && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (clr_i) begin
          pot_clr = 1'b1;
`ifdef LIF_REFRACTORY_EN
          for (int i = 0; i < NUM_NEURONS; i++) begin
            cnt_d[i] = '0;
          end
`endif
        end else if (tick_i) begin
          idx_d       = '0;
          spk_d       = '0;
          state_d     = StIssue;
          enter_issue = 1'b1;
        end
      end
      StIssue: begin
        if (skip_cur) begin
          // Refractory neuron: no handshake, potential and spike forced to 0.
          pot_we       = 1'b1;
          pot_wdata    = '0;
          spk_d[idx_q] = 1'b0;
          advance      = 1'b1;
`ifdef LIF_REFRACTORY_EN
          cnt_d[idx_q] = cnt_q[idx_q] - CNT_WIDTH'(1);
`endif
        end else if (upd_ready_i) begin
          upd_valid_d = 1'b0;
          state_d     = StWait;
        end
      end
      StWait: begin
        if (res_valid_i) begin
          pot_we       = 1'b1;
          spk_d[idx_q] = res_spike_i[0];
          state_d      = StWrite;
`ifdef LIF_REFRACTORY_EN
          if (res_spike_i[0]) begin
            pot_wdata    = '0;
            cnt_d[idx_q] = CNT_WIDTH'(REFRAC_TICKS);
          end
`endif
        end
      end
      StWrite: begin
        advance = 1'b1;
      end
      StDone: begin
        spikes_d = spk_q;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (advance) begin
      if (idx_q == LastIdx) begin
        state_d = StDone;
      end else begin
        idx_d       = idx_inc;
        state_d     = StIssue;
        enter_issue = 1'b1;
      end
    end

    if (enter_issue) begin
      upd_valid_d = ~skip_nxt;
      upd_v_d     = pot_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      spk_q       <= '0;
      spikes_q    <= '0;
      overrun_q   <= 1'b0;
      upd_valid_q <= 1'b0;
      upd_v_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      spk_q       <= spk_d;
      spikes_q    <= spikes_d;
      overrun_q   <= overrun_d;
      upd_valid_q <= upd_valid_d;
      upd_v_q     <= upd_v_d;
    end
  end

  assign upd_valid_o = upd_valid_q;
  assign upd_idx_o   = idx_q;
  assign upd_v_o     = upd_v_q;
  assign spikes_o    = spikes_q;
  assign done_o      = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_lif_scheduler.sv
// Self-checking bench for lif_scheduler: the bench acts as the LIF datapath and keeps a
// per-neuron potential/spike model to predict every request and the published spike vector.
module tb_lif_scheduler;

  localparam int N  = 4;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick_i = 1'b0;
  logic          clr_i = 1'b0;
  logic          upd_ready_i = 1'b0;
  logic          res_valid_i = 1'b0;
  logic [VW-1:0] res_v_i = '0;
  logic [0:0]    res_spike_i = '0;
  logic          upd_valid_o;
  logic [1:0]    upd_idx_o;
  logic [VW-1:0] upd_v_o;
  logic [N-1:0]  spikes_o;
  logic          done_o, busy_o, overrun_o;

  int            n_pass = 0;
  int            n_total = 0;
  int            pot_m [N];
  logic [N-1:0]  spk_m = '0;
  logic [N-1:0]  spikes_m = '0;
  logic          ovr_m = 1'b0;

  always #5 clk = ~clk;

  lif_scheduler dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_i     (tick_i),
    .clr_i      (clr_i),
    .upd_valid_o(upd_valid_o),
    .upd_ready_i(upd_ready_i),
    .upd_idx_o  (upd_idx_o),
    .upd_v_o    (upd_v_o),
    .res_valid_i(res_valid_i),
    .res_v_i    (res_v_i),
    .res_spike_i(res_spike_i),
    .spikes_o   (spikes_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .overrun_o  (overrun_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", upd_valid_o, 0);
    check("rst_idx", upd_idx_o, 0);
    check("rst_v", upd_v_o, 0);
    check("rst_spikes", spikes_o, 0);
    check("rst_done", done_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_overrun", overrun_o, 0);
  endtask

  // mode 0: v+10 no spike; 1: v+10, spike on odd idx; 2: random value and spike.
  task automatic run_step(input int mode, input int bp_idx, input bit rand_dly,
                          input int abort_idx, input bit ovr_tick);
    int            cyc;
    int            guard;
    bit            slow;
    logic [VW-1:0] nv;
    logic          sp;
    spk_m  = '0;
    slow   = 1'b0;
    tick_i = 1'b1;
    @(negedge clk);
    tick_i = 1'b0;
    cyc    = 1;
    check("busy_on_start", busy_o, 1);
    check("spikes_held", spikes_o, spikes_m);
    for (int n = 0; n < N; n++) begin
      int rdly, vdly;
      guard = 0;
      while (!upd_valid_o && guard < 20) begin
        @(negedge clk);
        cyc++;
        guard++;
      end
      check("req_valid", upd_valid_o, 1);
      check("req_idx", upd_idx_o, n);
      check("req_v", upd_v_o, pot_m[n]);
      rdly = (n == bp_idx) ? 5 : (rand_dly ? int'($urandom_range(0, 3)) : 0);
      vdly = (n == bp_idx) ? 3 : (rand_dly ? int'($urandom_range(0, 3)) : 0);
      if (rdly != 0 || vdly != 0) slow = 1'b1;
      for (int d = 0; d < rdly; d++) begin
        // Stray result strobes while a request is pending must be ignored.
        res_valid_i = 1'b1;
        res_v_i     = VW'($urandom);
        @(negedge clk);
        cyc++;
        check("hold_valid", upd_valid_o, 1);
        check("hold_idx", upd_idx_o, n);
        check("hold_v", upd_v_o, pot_m[n]);
      end
      res_valid_i = 1'b0;
      upd_ready_i = 1'b1;
      @(negedge clk);
      cyc++;
      upd_ready_i = 1'b0;
      if (n == abort_idx) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        for (int i = 0; i < N; i++) pot_m[i] = 0;
        spikes_m = '0;
        ovr_m    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      check("valid_drop", upd_valid_o, 0);
      for (int d = 0; d < vdly; d++) begin
        @(negedge clk);
        cyc++;
      end
      case (mode)
        0:       begin nv = VW'(pot_m[n] + 10); sp = 1'b0; end
        1:       begin nv = VW'(pot_m[n] + 10); sp = (n % 2 == 1); end
        default: begin nv = VW'($urandom); sp = 1'($urandom); end
      endcase
      res_valid_i    = 1'b1;
      res_v_i        = nv;
      res_spike_i[0] = sp;
      if (ovr_tick && n == 1) tick_i = 1'b1;
      @(negedge clk);
      cyc++;
      res_valid_i    = 1'b0;
      tick_i         = 1'b0;
      res_v_i        = VW'($urandom);
      res_spike_i[0] = 1'($urandom);
      if (ovr_tick && n == 1) ovr_m = 1'b1;
      pot_m[n] = int'(nv);
      spk_m[n] = sp;
    end
    guard = 0;
    while (!done_o && guard < 20) begin
      @(negedge clk);
      cyc++;
      guard++;
    end
    check("done_pulse", done_o, 1);
    if (!slow) check("latency", cyc, 3 * N + 1);
    check("overrun", overrun_o, ovr_m);
    @(negedge clk);
    spikes_m = spk_m;
    check("done_one_cycle", done_o, 0);
    check("busy_idle", busy_o, 0);
    check("spikes", spikes_o, spikes_m);
  endtask

  initial begin
    for (int i = 0; i < N; i++) pot_m[i] = 0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);

    run_step(0, -1, 1'b0, -1, 1'b0);  // all requests carry 0
    run_step(0, -1, 1'b0, -1, 1'b0);  // all requests carry 10
    run_step(1, -1, 1'b0, -1, 1'b0);  // spikes on idx 1 and 3
    run_step(0, 2, 1'b0, -1, 1'b0);   // backpressure and late result on idx 2
    run_step(0, -1, 1'b0, 2, 1'b0);   // reset during WAIT for neuron 2
    run_step(0, -1, 1'b0, -1, 1'b0);  // restarts at idx 0 from zero potentials
    run_step(2, -1, 1'b0, -1, 1'b1);  // tick while busy sets overrun

    clr_i  = 1'b1;
    tick_i = 1'b1;
    @(negedge clk);
    clr_i  = 1'b0;
    tick_i = 1'b0;
    check("clr_no_sweep", busy_o, 0);
    check("clr_overrun_kept", overrun_o, 1);
    for (int i = 0; i < N; i++) pot_m[i] = 0;
    @(negedge clk);
    check("clr_still_idle", busy_o, 0);
    run_step(0, -1, 1'b0, -1, 1'b0);  // potentials were cleared

    for (int k = 0; k < 6; k++) begin
      run_step(2, -1, 1'b1, -1, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
